// File: rtl/subneg_core.sv
// SUBNEG one-instruction computer: each instruction {A,B,C} does mem[B] -= mem[A]
// and branches to C on the configured condition; runs in FETCH/READ/EXEC, three cycles per instruction.
module subneg_core #(
    parameter int             DW       = 8,
    parameter int             AW       = 5,
    parameter int             BR_MODE  = 0,
    parameter logic [AW-1:0]  OUT_ADDR = {AW{1'b1}},
    parameter logic [AW-1:0]  IN_ADDR  = {{(AW-1){1'b1}}, 1'b0}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          step,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READ  = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DW-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          halted_q, halted_d;
    logic          busy_q, busy_d;
    logic          step_mode_q, step_mode_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [DW-1:0] mem_wdata_s;
    logic [DW-1:0] result_s;
    logic          take_s;

    // I/O-mapped operand read: the ports shadow the memory words at their addresses
    function automatic logic [DW-1:0] operand(input logic [AW-1:0] addr,
                                              input logic [DW-1:0] mem_word,
                                              input logic [DW-1:0] in_word,
                                              input logic [DW-1:0] out_word);
        logic [DW-1:0] v;
        if (addr == IN_ADDR) begin
            v = in_word;
        end else if (addr == OUT_ADDR) begin
            v = out_word;
        end else begin
            v = mem_word;
        end
        return v;
    endfunction

    function automatic logic branch_taken(input logic [DW-1:0] va,
                                          input logic [DW-1:0] vb,
                                          input logic [DW-1:0] r);
        logic t;
        case (BR_MODE)
            32'sd0:  t = (va > vb);
            32'sd1:  t = r[DW-1];
            32'sd2:  t = r[DW-1] | (r == {DW{1'b0}});
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign result_s = val_b_q - val_a_q;
    assign take_s   = branch_taken(val_a_q, val_b_q, result_s);

    // Next-state, datapath and memory-write decode; reset folds into the _d values
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        val_a_d     = val_a_q;
        val_b_d     = val_b_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        step_mode_d = step_mode_q;
        busy_d      = busy_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = load_addr;
        mem_wdata_s = load_data;

        if (reset) begin
            state_d     = ST_IDLE;
            pc_d        = {AW{1'b0}};
            a_d         = {AW{1'b0}};
            b_d         = {AW{1'b0}};
            c_d         = {AW{1'b0}};
            val_a_d     = {DW{1'b0}};
            val_b_d     = {DW{1'b0}};
            out_data_d  = {DW{1'b0}};
            halted_d    = 1'b0;
            step_mode_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_we) begin
                        mem_we_s = 1'b1;
                    end else if (!halted_q && (run || step)) begin
                        state_d     = ST_FETCH;
                        step_mode_d = !run;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    a_d     = mem_q[pc_q][AW-1:0];
                    b_d     = mem_q[pc_q + AW'(1)][AW-1:0];
                    c_d     = mem_q[pc_q + AW'(2)][AW-1:0];
                    state_d = ST_READ;
                end
                ST_READ: begin
                    val_a_d = operand(a_q, mem_q[a_q], in_data, out_data_q);
                    val_b_d = operand(b_q, mem_q[b_q], in_data, out_data_q);
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    if (b_q == OUT_ADDR) begin
                        out_data_d  = result_s;
                        out_valid_d = 1'b1;
                    end else if (b_q == IN_ADDR) begin
                        out_data_d = out_data_q;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = b_q;
                        mem_wdata_s = result_s;
                    end
                    if (take_s) begin
                        pc_d = c_q;
                    end else begin
                        pc_d = pc_q + AW'(3);
                    end
                    // a taken branch onto itself is the halt idiom
                    if (take_s && (c_q == pc_q)) begin
                        halted_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (run && !step_mode_q) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            busy_d = (state_d != ST_IDLE);
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        pc_q        <= pc_d;
        a_q         <= a_d;
        b_q         <= b_d;
        c_q         <= c_d;
        val_a_q     <= val_a_d;
        val_b_q     <= val_b_d;
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
        halted_q    <= halted_d;
        busy_q      <= busy_d;
        step_mode_q <= step_mode_d;
    end

    // Program/data memory; never reset, write enable already suppressed under reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_subneg_core.sv
// Bench for subneg_core: three instances (branch modes 0/1/2) share stimulus and are
// compared against an instruction-level reference model of the SUBNEG machine.
module tb_subneg_core;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 32;
    localparam int OUT_A = 31;
    localparam int IN_A  = 30;

    logic          clk = 1'b0;
    logic          reset, run, step, load_we;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data, in_data;
    logic [DW-1:0] out_data_s [3];
    logic          out_valid_s [3];
    logic          busy_s [3];
    logic          halted_s [3];
    logic [AW-1:0] pc_s [3];

    int n_checks = 0;
    int n_pass   = 0;

    int mm [3][DEPTH];
    int mpc [3];
    int mout [3];
    bit mhalt [3];
    bit mov [3];

    always #5 clk = ~clk;

    subneg_core #(.DW(DW), .AW(AW), .BR_MODE(0)) u0 (
        .clk(clk), .reset(reset), .run(run), .step(step), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .in_data(in_data),
        .out_data(out_data_s[0]), .out_valid(out_valid_s[0]), .busy(busy_s[0]),
        .halted(halted_s[0]), .pc(pc_s[0]));
    subneg_core #(.DW(DW), .AW(AW), .BR_MODE(1)) u1 (
        .clk(clk), .reset(reset), .run(run), .step(step), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .in_data(in_data),
        .out_data(out_data_s[1]), .out_valid(out_valid_s[1]), .busy(busy_s[1]),
        .halted(halted_s[1]), .pc(pc_s[1]));
    subneg_core #(.DW(DW), .AW(AW), .BR_MODE(2)) u2 (
        .clk(clk), .reset(reset), .run(run), .step(step), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .in_data(in_data),
        .out_data(out_data_s[2]), .out_valid(out_valid_s[2]), .busy(busy_s[2]),
        .halted(halted_s[2]), .pc(pc_s[2]));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int dut_mem(input int idx, input int addr);
        case (idx)
            0:       return int'(u0.mem_q[addr]);
            1:       return int'(u1.mem_q[addr]);
            default: return int'(u2.mem_q[addr]);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int model_read(input int idx, input int addr);
        if (addr == IN_A) return int'(in_data);
        if (addr == OUT_A) return mout[idx];
        return mm[idx][addr];
    endfunction

    task automatic model_step(input int idx);
        int p, a, b, c, va, vb, r;
        bit take;
        mov[idx] = 1'b0;
        if (mhalt[idx]) return;
        p  = mpc[idx];
        a  = mm[idx][p] % DEPTH;
        b  = mm[idx][(p + 1) % DEPTH] % DEPTH;
        c  = mm[idx][(p + 2) % DEPTH] % DEPTH;
        va = model_read(idx, a);
        vb = model_read(idx, b);
        r  = (vb - va + 256) % 256;
        case (idx)
            0:       take = (va > vb);
            1:       take = (r >= 128);
            default: take = (r >= 128) || (r == 0);
        endcase
        if (b == OUT_A) begin
            mout[idx] = r;
            mov[idx]  = 1'b1;
        end else if (b != IN_A) begin
            mm[idx][b] = r;
        end
        if (take) begin
            if (c == p) mhalt[idx] = 1'b1;
            mpc[idx] = c;
        end else begin
            mpc[idx] = (p + 3) % DEPTH;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mpc[i] = 0; mout[i] = 0; mhalt[i] = 1'b0; mov[i] = 1'b0;
        end
    endtask

    task automatic load(input int addr, input int data);
        load_we   = 1'b1;
        load_addr = AW'(addr);
        load_data = DW'(data);
        tick();
        load_we = 1'b0;
        for (int i = 0; i < 3; i++) mm[i][addr] = data % 256;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("%s_pc%0d", tag, i), 32'(pc_s[i]), 32'(mpc[i]));
            check_val($sformatf("%s_out%0d", tag, i), 32'(out_data_s[i]), 32'(mout[i]));
            check_val($sformatf("%s_halt%0d", tag, i), 32'(halted_s[i]), 32'(mhalt[i]));
            check_val($sformatf("%s_ov%0d", tag, i), 32'(out_valid_s[i]), 32'(mov[i]));
        end
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 3; i++)
            check_val($sformatf("%s_busy%0d", tag, i), 32'(busy_s[i]), 32'd0);
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < DEPTH; a++)
                check_val($sformatf("%s_m%0d_%0d", tag, i, a), 32'(dut_mem(i, a)), 32'(mm[i][a]));
    endtask

    // one step-initiated instruction; optional load_we noise while busy
    task automatic exec_one(input string tag, input bit noise);
        int  cnt [3];
        bit  was_halted [3];
        int  na, nd;
        na = $urandom_range(0, DEPTH - 1);
        nd = $urandom_range(0, 255);
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            was_halted[i] = mhalt[i];
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        if (noise) begin
            load_we   = 1'b1;
            load_addr = AW'(na);
            load_data = DW'(nd);
        end
        repeat (3) begin
            for (int i = 0; i < 3; i++) cnt[i] += int'(busy_s[i]);
            tick();
        end
        load_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_step(i);
            if (noise && was_halted[i]) mm[i][na] = nd;
        end
        check_state(tag);
        check_idle(tag);
        for (int i = 0; i < 3; i++)
            check_val($sformatf("%s_bcnt%0d", tag, i), 32'(cnt[i]), was_halted[i] ? 32'd0 : 32'd3);
        tick();
        for (int i = 0; i < 3; i++)
            check_val($sformatf("%s_ovoff%0d", tag, i), 32'(out_valid_s[i]), 32'd0);
    endtask

    // n instructions under run=1; run drops during the last one
    task automatic run_n(input string tag, input int n);
        run = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) run = 1'b0;
            repeat (3) tick();
            for (int i = 0; i < 3; i++) model_step(i);
            check_state($sformatf("%s_i%0d", tag, k));
        end
        check_idle(tag);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; load_we = 1'b0;
        load_addr = '0; load_data = '0; in_data = '0;
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) load(a, $urandom_range(0, 255));

        // reset leaves memory intact
        apply_reset();
        check_state("rst");
        check_idle("rst");
        compare_mem("rst");

        // output-port write with taken branch
        load(0, 20); load(1, 31); load(2, 3); load(20, 60);
        run_n("out", 1);
        check_val("out_data", 32'(out_data_s[0]), 32'd196);
        check_val("out_valid", 32'(out_valid_s[0]), 32'd1);
        check_val("out_pc", 32'(pc_s[0]), 32'd3);

        // halt on self-branch, run afterwards ignored
        apply_reset();
        load(0, 19); load(1, 18); load(2, 0); load(19, 1); load(18, 0);
        run_n("halt", 1);
        check_val("halt_m18", 32'(dut_mem(0, 18)), 32'd255);
        check_val("halt_flag", 32'(halted_s[0]), 32'd1);
        check_val("halt_pc", 32'(pc_s[0]), 32'd0);
        run_n("halt_again", 2);

        // single step, not taken
        apply_reset();
        load(0, 10); load(1, 11); load(2, 7); load(10, 3); load(11, 9);
        exec_one("step", 1'b0);
        check_val("step_pc", 32'(pc_s[0]), 32'd3);

        // input port operand; then zero result in mode 2
        apply_reset();
        load(0, 30); load(1, 18); load(2, 3); load(18, 10);
        in_data = 8'd5;
        exec_one("inport", 1'b0);
        check_val("inport_m18", 32'(dut_mem(0, 18)), 32'd5);
        apply_reset();
        load(18, 5);
        exec_one("zero", 1'b0);
        check_val("zero_m18", 32'(dut_mem(2, 18)), 32'd0);
        check_val("zero_pc2", 32'(pc_s[2]), 32'd3);

        // wrap-around fetch at pc=30 plus loads while busy
        apply_reset();
        load(0, 20); load(1, 21); load(2, 30); load(20, 60); load(21, 0);
        load(30, 22); load(31, 23); load(22, 0); load(23, 50);
        exec_one("wrap_a", 1'b0);
        exec_one("wrap_b", 1'b1);
        check_val("wrap_pc", 32'(pc_s[0]), 32'd1);
        compare_mem("wrap");

        // load has priority over start
        apply_reset();
        run = 1'b1; load_we = 1'b1; load_addr = 5'd5; load_data = 8'hA5;
        tick();
        run = 1'b0; load_we = 1'b0;
        for (int i = 0; i < 3; i++) mm[i][5] = 8'hA5;
        check_idle("prio");
        check_val("prio_m5", 32'(dut_mem(0, 5)), 32'hA5);

        // reset during EXEC aborts the instruction
        load(0, 20); load(1, 21); load(2, 9); load(20, 7); load(21, 100);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        apply_reset();
        check_state("abort");
        check_idle("abort");
        compare_mem("abort");

        // randomized programs
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            for (int a = 0; a < DEPTH; a++) load(a, $urandom_range(0, 255));
            repeat (6) begin
                in_data = DW'($urandom_range(0, 255));
                exec_one($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
            end
            in_data = DW'($urandom_range(0, 255));
            run_n($sformatf("rndrun%0d", r), 8);
            compare_mem($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/subneg_core.md
SUBNEG_CORE -- requirements
Module: subneg_core

Interface
REQ-001 Parameter DW, default 8: data word width in bits.
REQ-002 Parameter AW, default 5: address width; memory depth SHALL be 2**AW words.
REQ-003 Parameter BR_MODE, default 0: branch rule. 0 = unsigned borrow (A > B); 1 = signed result < 0; 2 = signed result <= 0.
REQ-004 Parameter OUT_ADDR, default 2**AW-1: memory-mapped output port address.
REQ-005 Parameter IN_ADDR, default 2**AW-2: memory-mapped input port address.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 run  in  1  level; 1 = execute instructions continuously.
REQ-009 step  in  1  single-instruction request, sampled in IDLE.
REQ-010 load_we  in  1  program/data write strobe.
REQ-011 load_addr  in  AW  write address.
REQ-012 load_data  in  DW  write data.
REQ-013 in_data  in  DW  input port value.
REQ-014 out_data  out  DW  registered output port value.
REQ-015 out_valid  out  1  one-cycle pulse when out_data is updated.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 halted  out  1  sticky halt flag.
REQ-018 pc  out  AW  current program counter.

Function
REQ-019 Memory SHALL be 2**AW x DW; address fields SHALL use the low AW bits of a word; all address arithmetic SHALL wrap modulo 2**AW.
REQ-020 FSM states: IDLE, FETCH, READ, EXEC. Each instruction SHALL take exactly 3 cycles (FETCH, READ, EXEC).
REQ-021 IDLE -> FETCH when not halted and (run=1 or step=1) and load_we=0; otherwise IDLE is held.
REQ-022 FETCH SHALL latch A=mem[pc], B=mem[pc+1], C=mem[pc+2] from the raw array; I/O mapping does not apply to fetch.
REQ-023 READ SHALL latch valA=mem[A] and valB=mem[B]. An operand address equal to IN_ADDR SHALL return in_data. An operand address equal to OUT_ADDR SHALL return out_data.
REQ-024 EXEC SHALL compute R = (valB - valA) mod 2**DW.
REQ-025 In EXEC, if B = OUT_ADDR: out_data <= R and out_valid = 1 for that cycle; memory is unchanged.
REQ-026 In EXEC, if B = IN_ADDR: R is discarded.
REQ-027 In EXEC, for any other B: mem[B] <= R.
REQ-028 In EXEC, branch taken per BR_MODE: pc <= C. Not taken: pc <= pc+3 (wrapping).
REQ-029 A taken branch with C equal to the pc of the executing instruction SHALL set halted=1 and go to IDLE.
REQ-030 After EXEC: next state FETCH if run=1 and not halted, else IDLE. A step-initiated instruction SHALL return to IDLE.
REQ-031 Deasserting run mid-instruction SHALL let the instruction complete, then go to IDLE.
REQ-032 load_we SHALL write mem[load_addr] only in IDLE; it SHALL be ignored otherwise. It has priority over starting execution in the same cycle.
REQ-033 Memory writes in EXEC and loads SHALL be visible to reads starting the following cycle.

Reset
REQ-034 On reset: state=IDLE, pc=0, out_data=0, out_valid=0, halted=0, busy=0, internal A/B/C/valA/valB=0.
REQ-035 Reset SHALL NOT alter memory contents.
REQ-036 Reset asserted mid-instruction SHALL abort it with no memory or out_data write in that cycle.

Verification (DW=8, AW=5, BR_MODE=0 unless stated)
REQ-037 Reset -> pc=0, out_data=0, out_valid=0, halted=0, busy=0; pre-loaded memory words unchanged.
REQ-038 Load mem[0..2]={20,31,3}, mem[20]=60, then run=1 -> third cycle after start: out_data=196, out_valid pulse, pc=3 (branch taken, 60>0).
REQ-039 Load mem[0..2]={19,18,0}, mem[19]=1, mem[18]=0, then run=1 -> after 3 cycles: mem[18]=255, halted=1, busy=0, pc=0; further run is ignored.
REQ-040 run=0, one-cycle step pulse, instruction not taken -> busy exactly 3 cycles, pc advances 0 -> 3, returns to IDLE.
REQ-041 Instruction {30,18,3}, in_data=5, mem[18]=10 -> mem[18]=5, no branch. Repeat with BR_MODE=2 and mem[18]=5 -> result 0, branch taken to 3.
REQ-042 pc=30 (mode 0), instruction not taken -> C fetched from mem[0], next pc=1. load_we pulsed while busy -> memory unchanged.
